// File: rtl/victim_ctrl_if.sv
// ---------------------------------------------------------------------------
// victim_ctrl_if
// Bundles every bus signal between the victim-buffer miss sequencer and its
// environment (L1 miss requesters, cache victim source, victim buffer array,
// memory port, fill port).
//   master : the sequencer (victim_ctrl)
//   slave  : the environment (caches / victim buffer / memory)
// Entry format for all 80-bit entries: {valid, dirty, line_addr, data}.
// ---------------------------------------------------------------------------
interface victim_ctrl_if #(
    parameter int AW = 14,
    parameter int DW = 64
);
    localparam int EW = AW + DW + 2;

    // miss requests
    logic          i_miss;
    logic [AW-1:0] i_addr;
    logic          d_miss;
    logic [AW-1:0] d_addr;
    // cache victim line
    logic          ev_valid;
    logic          ev_dirty;
    logic [AW-1:0] ev_addr;
    logic [DW-1:0] ev_data;
    // victim buffer probe / write
    logic [AW-1:0] vb_addr_i;
    logic [AW-1:0] vb_addr_d;
    logic          vb_ihit;
    logic          vb_hit;
    logic [1:0]    vb_hit_ind;
    logic [EW-1:0] vb_rd_data;
    logic [EW-1:0] vb_ev_data;
    logic [1:0]    vb_victim_index;
    logic          vb_we;
    logic [1:0]    vb_wr_line;
    logic [EW-1:0] vb_wr_data;
    logic          vb_roll;
    // memory port
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rdy;
    logic [DW-1:0] mem_rdata;
    // fill / completion
    logic          fill_valid;
    logic          fill_iside;
    logic          fill_dirty;
    logic [AW-1:0] fill_addr;
    logic [DW-1:0] fill_data;
    logic          i_done;
    logic          d_done;

    modport master (
        input  i_miss, i_addr, d_miss, d_addr,
        input  ev_valid, ev_dirty, ev_addr, ev_data,
        input  vb_hit, vb_hit_ind, vb_rd_data, vb_ev_data, vb_victim_index,
        input  mem_rdy, mem_rdata,
        output vb_addr_i, vb_addr_d, vb_ihit, vb_we, vb_wr_line, vb_wr_data, vb_roll,
        output mem_re, mem_we, mem_addr, mem_wdata,
        output fill_valid, fill_iside, fill_dirty, fill_addr, fill_data,
        output i_done, d_done
    );

    modport slave (
        output i_miss, i_addr, d_miss, d_addr,
        output ev_valid, ev_dirty, ev_addr, ev_data,
        output vb_hit, vb_hit_ind, vb_rd_data, vb_ev_data, vb_victim_index,
        output mem_rdy, mem_rdata,
        input  vb_addr_i, vb_addr_d, vb_ihit, vb_we, vb_wr_line, vb_wr_data, vb_roll,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        input  fill_valid, fill_iside, fill_dirty, fill_addr, fill_data,
        input  i_done, d_done
    );
endinterface

// File: rtl/victim_ctrl.sv
// ---------------------------------------------------------------------------
// victim_ctrl
// Miss sequencer for the 4-entry victim buffer sitting between the I/D L1
// caches and memory. Arbitrates I/D misses, probes the victim buffer, swaps on
// a hit, otherwise writes back a dirty buffer slot, fills from memory and
// inserts the cache victim (advancing the evict pointer).
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   bus  : victim_ctrl_if.master (miss requests, victim line, victim buffer,
//          memory and fill/done signals)
//
// Optional feature macro: VB_CTRL_RR_ARB_EN
//   defined   : round-robin grant on simultaneous misses
//   undefined : fixed priority, D-side wins
// ---------------------------------------------------------------------------
module victim_ctrl #(
    parameter int AW = 14,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    victim_ctrl_if.master bus
);
    localparam int EW = AW + DW + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_SWAP, S_WB_VB, S_FILL, S_INSERT, S_DONE
    } state_t;

    state_t        state_q;
    logic          side_i_q;       // 1 = I-side request granted
    logic [AW-1:0] req_addr_q;
    logic          ev_valid_q;
    logic          ev_dirty_q;
    logic [AW-1:0] ev_addr_q;
    logic [DW-1:0] ev_data_q;

    logic [AW-1:0] vb_addr_i_q, vb_addr_d_q;
    logic          vb_ihit_q, vb_we_q, vb_roll_q;
    logic [1:0]    vb_wr_line_q;
    logic [EW-1:0] vb_wr_data_q;
    logic          mem_re_q, mem_we_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic          fill_valid_q, fill_iside_q, fill_dirty_q;
    logic [AW-1:0] fill_addr_q;
    logic [DW-1:0] fill_data_q;
    logic          i_done_q, d_done_q;

    logic          grant_i_d;
    logic [EW-1:0] ev_entry;

    // The hit entry's valid bit and address are implied by the hit itself.
    logic unused_rd_bits;
    assign unused_rd_bits = ^{bus.vb_rd_data[EW-1], bus.vb_rd_data[DW +: AW]};

    assign ev_entry = {1'b1, ev_dirty_q, ev_addr_q, ev_data_q};

`ifdef VB_CTRL_RR_ARB_EN
    logic last_grant_i_q;

    // On a tie, hand the grant to the side that did not win last time.
    always_comb begin
        grant_i_d = bus.i_miss && (!bus.d_miss || !last_grant_i_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_i_q <= 1'b1;
        end else if (state_q == S_IDLE && (bus.i_miss || bus.d_miss)) begin
            last_grant_i_q <= grant_i_d;
        end
    end
`else
    always_comb begin
        grant_i_d = bus.i_miss && !bus.d_miss;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            side_i_q     <= 1'b0;
            req_addr_q   <= '0;
            ev_valid_q   <= 1'b0;
            ev_dirty_q   <= 1'b0;
            ev_addr_q    <= '0;
            ev_data_q    <= '0;
            vb_addr_i_q  <= '0;
            vb_addr_d_q  <= '0;
            vb_ihit_q    <= 1'b0;
            vb_we_q      <= 1'b0;
            vb_roll_q    <= 1'b0;
            vb_wr_line_q <= '0;
            vb_wr_data_q <= '0;
            mem_re_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            fill_valid_q <= 1'b0;
            fill_iside_q <= 1'b0;
            fill_dirty_q <= 1'b0;
            fill_addr_q  <= '0;
            fill_data_q  <= '0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
        end else begin
            // single-cycle strobes fall back to zero unless re-armed below
            vb_we_q      <= 1'b0;
            vb_roll_q    <= 1'b0;
            fill_valid_q <= 1'b0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.i_miss || bus.d_miss) begin
                        side_i_q   <= grant_i_d;
                        req_addr_q <= grant_i_d ? bus.i_addr : bus.d_addr;
                        ev_valid_q <= bus.ev_valid;
                        ev_dirty_q <= bus.ev_dirty;
                        ev_addr_q  <= bus.ev_addr;
                        ev_data_q  <= bus.ev_data;
                        vb_ihit_q  <= grant_i_d;
                        if (grant_i_d) begin
                            vb_addr_i_q <= bus.i_addr;
                        end else begin
                            vb_addr_d_q <= bus.d_addr;
                        end
                        state_q <= S_LOOKUP;
                    end
                end

                S_LOOKUP: begin
                    if (bus.vb_hit) begin
                        // swap: hit line goes to the cache, cache victim
                        // (or an invalid entry) takes its slot
                        fill_valid_q <= 1'b1;
                        fill_iside_q <= side_i_q;
                        fill_dirty_q <= bus.vb_rd_data[EW-2];
                        fill_addr_q  <= req_addr_q;
                        fill_data_q  <= bus.vb_rd_data[DW-1:0];
                        vb_we_q      <= 1'b1;
                        vb_wr_line_q <= bus.vb_hit_ind;
                        vb_wr_data_q <= ev_valid_q ? ev_entry : '0;
                        state_q      <= S_SWAP;
                    end else if (ev_valid_q && bus.vb_ev_data[EW-1] && bus.vb_ev_data[EW-2]) begin
                        // slot about to be overwritten holds dirty data
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= bus.vb_ev_data[DW +: AW];
                        mem_wdata_q <= bus.vb_ev_data[DW-1:0];
                        state_q     <= S_WB_VB;
                    end else begin
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= req_addr_q;
                        state_q    <= S_FILL;
                    end
                end

                S_SWAP: begin
                    i_done_q <= side_i_q;
                    d_done_q <= !side_i_q;
                    state_q  <= S_DONE;
                end

                S_WB_VB: begin
                    if (bus.mem_rdy) begin
                        mem_we_q   <= 1'b0;
                        mem_re_q   <= 1'b1;
                        mem_addr_q <= req_addr_q;
                        state_q    <= S_FILL;
                    end
                end

                S_FILL: begin
                    if (bus.mem_rdy) begin
                        mem_re_q     <= 1'b0;
                        fill_valid_q <= 1'b1;
                        fill_iside_q <= side_i_q;
                        fill_dirty_q <= 1'b0;
                        fill_addr_q  <= req_addr_q;
                        fill_data_q  <= bus.mem_rdata;
                        if (ev_valid_q) begin
                            vb_we_q      <= 1'b1;
                            vb_wr_line_q <= bus.vb_victim_index;
                            vb_wr_data_q <= ev_entry;
                            vb_roll_q    <= 1'b1;
                        end
                        state_q <= S_INSERT;
                    end
                end

                S_INSERT: begin
                    i_done_q <= side_i_q;
                    d_done_q <= !side_i_q;
                    state_q  <= S_DONE;
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.vb_addr_i  = vb_addr_i_q;
    assign bus.vb_addr_d  = vb_addr_d_q;
    assign bus.vb_ihit    = vb_ihit_q;
    assign bus.vb_we      = vb_we_q;
    assign bus.vb_wr_line = vb_wr_line_q;
    assign bus.vb_wr_data = vb_wr_data_q;
    assign bus.vb_roll    = vb_roll_q;
    assign bus.mem_re     = mem_re_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.fill_valid = fill_valid_q;
    assign bus.fill_iside = fill_iside_q;
    assign bus.fill_dirty = fill_dirty_q;
    assign bus.fill_addr  = fill_addr_q;
    assign bus.fill_data  = fill_data_q;
    assign bus.i_done     = i_done_q;
    assign bus.d_done     = d_done_q;
endmodule

// File: doc/victim_ctrl.md
Name: victim_ctrl

Overview:
- Miss sequencer for the 4-entry victim buffer between the I/D L1 caches and memory.
- Arbitrates I-side and D-side misses and probes the victim buffer. On a hit it swaps the line with the cache victim. On a miss it writes back a dirty buffer slot if needed, fills from memory, then inserts the cache victim and advances the buffer's evict pointer.
- Entry format everywhere: {valid[79], dirty[78], line_addr[77:64], data[63:0]}.

Parameters:
- AW, 14, line address width.
- DW, 64, line data width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- i_miss  in  1  I-cache miss request (level; held until i_done)
- i_addr  in  AW  I-side miss line address
- d_miss  in  1  D-cache miss request (level; held until d_done)
- d_addr  in  AW  D-side miss line address
- ev_valid / ev_dirty  in  1 / 1  cache victim line valid / dirty
- ev_addr / ev_data  in  AW / DW  cache victim line address / data
- vb_addr_i / vb_addr_d  out  AW / AW  victim-buffer probe addresses (latched request address on the granted side)
- vb_ihit  out  1  victim-buffer read-side select (1 = I-side)
- vb_hit  in  1  victim-buffer hit for the selected side
- vb_hit_ind  in  2  hit slot index
- vb_rd_data  in  80  hit entry
- vb_ev_data  in  80  entry at evict pointer
- vb_victim_index  in  2  evict pointer
- vb_we  out  1  victim-buffer write strobe
- vb_wr_line  out  2  victim-buffer write slot
- vb_wr_data  out  80  victim-buffer write entry
- vb_roll  out  1  advance evict pointer (1-cycle pulse)
- mem_re / mem_we  out  1 / 1  memory read / write request (held until mem_rdy)
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdy  in  1  memory done; mem_rdata valid in the same cycle
- mem_rdata  in  DW  memory read data
- fill_valid  out  1  1-cycle cache fill strobe
- fill_iside  out  1  fill target (1 = I-cache)
- fill_dirty  out  1  dirty bit of filled line
- fill_addr / fill_data  out  AW / DW  fill line address / data
- i_done / d_done  out  1 / 1  1-cycle completion pulses

Behaviour:
- Reset (async): state IDLE, grant latch cleared, last-grant = I. All strobes (vb_we, vb_roll, mem_re, mem_we, fill_valid, i_done, d_done) = 0. Data/address outputs = 0.
- States: IDLE, LOOKUP, SWAP, WB_VB, FILL, INSERT, DONE.
- IDLE, any miss pending:
  - Arbitrate (fixed: D wins).
  - Latch side, request address and ev_* fields.
  - Go to LOOKUP.
- LOOKUP, 1 cycle; probe addresses driven, vb_hit sampled:
  - vb_hit → SWAP.
  - Else, if latched ev_valid and vb_ev_data[79] and vb_ev_data[78] → WB_VB.
  - Else → FILL.
- SWAP, 1 cycle:
  - fill_valid=1, fill_data=vb_rd_data[63:0], fill_dirty=vb_rd_data[78].
  - vb_we=1 to slot vb_hit_ind:
    - latched ev_valid=1: write {1, ev_dirty, ev_addr, ev_data}.
    - latched ev_valid=0: write 80'h0 (invalidate).
  - No roll. → DONE.
- WB_VB:
  - mem_we=1, mem_addr=vb_ev_data[77:64], mem_wdata=vb_ev_data[63:0].
  - Held until mem_rdy. → FILL.
- FILL:
  - mem_re=1, mem_addr=latched request address.
  - Held until mem_rdy; capture mem_rdata. → INSERT.
- INSERT, 1 cycle:
  - fill_valid=1, fill_dirty=0.
  - If latched ev_valid: vb_we=1, vb_wr_line=vb_victim_index, vb_wr_data={1, ev_dirty, ev_addr, ev_data}, vb_roll=1.
  - Otherwise no write and no roll. A valid clean slot is overwritten silently.
  - → DONE.
- DONE: pulse i_done or d_done for the granted side; miss inputs ignored this cycle. → IDLE.
- Latency: VB hit = done 3 cycles after the grant edge; miss = 4 cycles + memory wait(s).
- mem_re and mem_we are never high together.
- vb_we and vb_roll occur only in SWAP/INSERT, and at most once per request.
- Reset mid-operation: strobes drop immediately; no done pulse; the requester re-issues the miss.
- A miss on the non-granted side stays pending and is arbitrated at the next IDLE.

Optional Feature:
- Macro VB_CTRL_RR_ARB_EN.
- Defined: round-robin on simultaneous misses — grant the side opposite last-grant. Last-grant updates on each grant.
- Undefined: fixed priority, D-side always wins.

Test Plan:
- Hit/swap, D side:
  - Stimulus: d_miss addr 0x0123; VB slot 2 = {1,0,0x0123,A}; ev = {1,1,0x0456,B}.
  - Response: fill A with dirty 0; vb_we line 2 with {1,1,0x0456,B}; no mem_re/mem_we; no roll; d_done 3 cycles after the grant edge.
- Dirty writeback then fill, I side:
  - Stimulus: i_miss 0x0010, VB miss; victim_index 1 holding {1,1,0x0777,C}; ev valid; mem_rdy after 2 cycles each.
  - Response: mem_we addr 0x0777 data C; then mem_re addr 0x0010; fill mem_rdata with fill_iside=1; vb_we line 1; single vb_roll pulse; i_done.
- Clean/invalid victim-buffer slot:
  - Stimulus: VB miss, victim_index slot clean.
  - Response: no mem_we; FILL directly; insert and roll as usual.
- ev_valid=0 on VB miss:
  - Response: fill performed; vb_we=0; vb_roll=0; done pulses.
- Simultaneous i_miss and d_miss, three back-to-back rounds:
  - Fixed priority: D, D, D.
  - With VB_CTRL_RR_ARB_EN: D, I, D.
- rst asserted in WB_VB while mem_we=1:
  - Response: mem_we drops without a clock edge; state IDLE; no done.
  - After release, the held miss restarts from LOOKUP.
